// File: rtl/turn_queue.sv
// rtl/turn_queue.sv - direction press queue between button debouncers and snek core
module turn_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [1:0]  INIT_DIR = 2'd3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               buttons,
   input  logic                     step,
   input  logic                     clear,
   output logic [1:0]               dir,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     pending,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [1:0]    cand;
   logic [1:0]    last;
   logic          single;
   logic          accept;
   logic          reject;
   logic          pop;
   logic [CW-1:0] count_nxt;

   // Decode the press and decide accept/reject against the newest queued heading.
   always_comb begin
      cand = 2'd0;
      case (buttons)
         4'b1000: cand = 2'd0;
         4'b0100: cand = 2'd1;
         4'b0010: cand = 2'd2;
         4'b0001: cand = 2'd3;
         default: cand = 2'd0;
      endcase
      single    = (buttons != 4'd0) && ((buttons & (buttons - 4'd1)) == 4'd0);
      last      = (count != '0) ? mem[tail - AW'(1)] : dir;
      // Perpendicular turns differ in the vertical/horizontal bit; a full queue
      // refuses presses even when a step frees a slot in the same cycle.
      accept    = single && (cand[1] != last[1]) && (count != CW'(DEPTH));
      reject    = (buttons != 4'd0) && !accept;
      pop       = step && (count != '0);
      count_nxt = count + CW'(accept) - CW'(pop);
   end

   // Queue storage; contents are only read while count says they are valid.
   always_ff @(posedge clk) begin
      if (!clear && accept)
         mem[tail] <= cand;
   end

   // Pointers, count, heading and reject pulse; clear overrides push and step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         pending <= 1'b0;
         dir     <= INIT_DIR;
         dropped <= 1'b0;
      end else if (clear) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         pending <= 1'b0;
         dir     <= INIT_DIR;
         dropped <= 1'b0;
      end else begin
         if (accept)
            tail <= tail + AW'(1);
         if (pop) begin
            dir  <= mem[head];
            head <= head + AW'(1);
         end
         count   <= count_nxt;
         pending <= (count_nxt != '0);
         dropped <= reject;
      end
   end

endmodule

// File: doc/turn_queue.md
# turn_queue

Buffers player direction presses between the button debouncers and the snek game core. It accepts one-cycle press pulses and rejects reversals and no-op turns. Accepted turns are queued so that quick sequences (e.g. up then left within one game step) are not lost. On each game step it releases at most one turn to the game core as the current heading.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16
- INIT_DIR, 2'd3: heading after reset/clear; encoding 0=up, 1=down, 2=left, 3=right
- clk  in  1  game clock (VGA pixel clock domain)
- rst  in  1  reset, asynchronous, active-high
- buttons  in  4  {up,down,left,right} press pulses, one cycle wide, synchronous to clk
- step  in  1  one-cycle pulse: game advances one cell; consume one queued turn
- clear  in  1  synchronous restart (game over/new game): flush queue, heading := INIT_DIR
- dir  out  2  current heading presented to game core
- count  out  $clog2(DEPTH)+1  queued turns, 0..DEPTH
- pending  out  1  count != 0
- dropped  out  1  one-cycle pulse: a press was rejected this cycle

## Operation
- Storage: circular buffer of DEPTH 2-bit entries, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus count register.
- Press decode: buttons==0 means no press. Exactly one bit set gives candidate c (1000->0, 0100->1, 0010->2, 0001->3). More than one bit set is rejected.
- Reference heading "last" = entry at tail-1 if count>0, else dir; evaluated on pre-cycle state.
- Accept iff single press AND c[1] != last[1] (perpendicular only). Same direction and reversal are both rejected.
- Full: if count==DEPTH (pre-pop value), press is rejected even if step pops in the same cycle.
- Accept: write c at tail, tail+1.
- Reject, for any reason (multi-bit, same, reverse, full): dropped=1 for exactly the next cycle; no state change.
- Step: if count>0 (pre-push value), dir := entry at head, head+1. If count==0, dir holds.
- Push and step in the same cycle: both act; count := count+1-1. If empty at that cycle, the push is queued and does not affect dir until the next step.
- Clear has priority over push and step: head=tail=count=0, dir=INIT_DIR, dropped=0. A press in the clear cycle is discarded silently with no dropped pulse.
- No idle/running FSM beyond queue state; count encodes empty/partial/full.

## Timing
- Reset (async assert, registers released on clk): dir=INIT_DIR, count=0, pending=0, dropped=0, head=tail=0.
- All outputs registered.
- Press at cycle N: count/pending updated at N+1. dropped, if any, high during N+1 only.
- Step at cycle N: dir valid at N+1.
- Minimum press-to-heading latency is 2 cycles: press at N, step at N+1, dir at N+2.
- Back-to-back presses every cycle are supported. Each press is checked against the tail written the previous cycle.
- Back-to-back steps every cycle drain one entry per cycle.
- Pointer wrap: after DEPTH pushes and pops, pointers return to 0 with no loss.

## Test plan
- Reset: assert rst mid-operation with count=2 -> immediately dir=3, count=0, pending=0, dropped=0. After release, queue is empty.
- Single turn: dir=3, buttons=1000 one cycle -> count=1 next cycle. step -> dir=0, count=0 the cycle after step.
- Reject: dir=3, press 0010 (reverse) -> dropped pulse, count=0. Press 0001 (same) -> dropped. Press 1100 -> dropped. dir stays 3 throughout.
- Chained turns: dir=3, presses 1000, 0010, 0100 on consecutive cycles -> count=3. Three steps -> dir 0, 2, 1; count 0.
- Full (DEPTH=4): dir=3, presses up, left, down, right -> count=4. Fifth press (up) with simultaneous step -> dropped=1, dir=0, count=3.
- Empty push+step plus clear: count=0, dir=3, press 1000 and step same cycle -> dir=3, count=1. Next step -> dir=0. Queue 2 entries then clear with press -> count=0, dir=3, no dropped pulse.
